program_loader: RTL

Boot-time program loader sitting directly upstream of the CPU's instruction memory. It receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into instruction memory through a dedicated write port. It holds the CPU out of execution until the image is complete. Benches and boards load programs through this block instead of back-door memory initialisation.

---
 rtl/loader_pkg.sv | 10 +
 rtl/loader_word_assembler.sv | 36 +++
 rtl/program_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and stream-format constants for program_loader.
//   HDR_BYTES  - header length in bytes (big-endian word count)
//   WORD_BYTES - bytes per instruction word
//   CSUM_W     - width of the trailing XOR checksum byte
package loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CHECK, DONE, ERROR} state_t;
    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_W     = 8;
endpackage

// File: rtl/loader_word_assembler.sv
// loader_word_assembler: packs a byte stream MSB-first into 32-bit words.
//   clock, reset    - rising-edge clock, synchronous active-high reset
//   clear           - restart assembly at byte 0 of a new word
//   byte_in         - incoming byte
//   byte_valid      - byte_in is consumed this cycle
//   word            - assembled word (valid together with word_valid)
//   word_valid      - combinational pulse on the cycle the final byte of a word arrives
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [1:0]  cnt;
    logic [23:0] shreg;

    // The final byte is appended combinationally so the word is ready on its
    // accepting edge and the top can register the memory write from it.
    assign word       = {shreg, byte_in};
    assign word_valid = byte_valid && cnt == 2'(WORD_BYTES - 1);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (byte_valid) begin
            cnt   <= cnt + 2'd1;
            shreg <= {shreg[15:0], byte_in};
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a byte-streamed program into instruction memory and holds the CPU until done.
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   start                 - one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   in_data/in_valid/in_ready - byte stream handshake
//   imem_we/imem_addr/imem_wdata - registered instruction memory write port
//   cpu_run               - CPU may execute (image complete)
//   busy                  - load in progress
//   err                   - load failed, sticky until start or reset
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int INSTR_MEM_SIZE = 32,
    parameter int ADDR_WIDTH     = $clog2(INSTR_MEM_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  err
);
    state_t                state;
    logic [7:0]            hdr_hi;
    logic [15:0]           hdr;
    logic [ADDR_WIDTH:0]   n_words;
    logic [ADDR_WIDTH:0]   wcnt;
    logic                  accept;
    logic                  launch;
    logic [31:0]           word;
    logic                  word_valid;
`ifdef LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0]     csum;
`endif

    always_comb begin
        in_ready = state inside {HDR_HI, HDR_LO, DATA, CHECK};
        busy     = in_ready;
        accept   = in_valid && in_ready;
        launch   = start && state inside {IDLE, DONE, ERROR};
        hdr      = {hdr_hi, in_data};
    end

    loader_word_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (launch),
        .byte_in    (in_data),
        .byte_valid (accept && state == DATA),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            hdr_hi     <= '0;
            n_words    <= '0;
            wcnt       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_run    <= 1'b0;
            err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            // Status outputs lag the state by one edge so the last write lands first.
            cpu_run <= state == DONE;
            err     <= state == ERROR;
`ifdef LOADER_CHECKSUM_EN
            if (accept) csum <= csum ^ in_data;
`endif
            case (state)
                IDLE, DONE, ERROR: if (start) begin
                    state <= HDR_HI;
                    wcnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
                    csum  <= '0;
`endif
                end
                HDR_HI: if (accept) begin
                    hdr_hi <= in_data;
                    state  <= HDR_LO;
                end
                HDR_LO: if (accept) begin
                    n_words <= hdr[ADDR_WIDTH:0];
                    state   <= hdr == '0 ? DONE : hdr > 16'(INSTR_MEM_SIZE) ? ERROR : DATA;
                end
                DATA: if (word_valid) begin
                    imem_we    <= 1'b1;
                    imem_wdata <= word;
                    imem_addr  <= wcnt[ADDR_WIDTH-1:0];
                    wcnt       <= wcnt + 1'b1;
                    if ((wcnt + 1'b1) == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= CHECK;
`else
                        state <= DONE;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: if (accept) state <= in_data == csum ? DONE : ERROR;
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
